status_clear_cdc_mc: RTL and testbench
======================================

# status_clear_cdc_mc

Multi-channel, parametrised toggle-handshake CDC that carries status-clear requests from `NUM_CH` slow or asynchronous source domains (SPI SCK ports, debug port) into the HF_CLK domain. Each request is a quasi-static mask plus a request toggle. The block synchronises both, waits a programmable settle time, and then arbitrates among ready channels. It issues one registered clear pulse with a held mask to the status monitor, and returns a per-channel ack toggle. It replaces the single-channel, fixed-width status-clear CDC.

## Interface
- `NUM_CH`, 2: number of source channels (1..8).
- `MASK_W`, 14: status mask width (1..32).
- `SYNC_STAGES`, 2: synchroniser depth for toggle and mask (2..4).
- `SETTLE`, 2: HF_CLK cycles between edge detection and readiness (0..15).
- `MERGE`, 0: 0 = round-robin, one channel per pulse; 1 = all ready channels combined into one pulse.

- `HF_CLK` in 1: destination clock, always running.
- `NRST_sync` in 1: reset, asynchronous, active-low.
- `clr_req_tgl_src` in `NUM_CH`: per-channel request toggles from the source domains.
- `clr_mask_src` in `NUM_CH*MASK_W`: channel c mask at bits [c*MASK_W +: MASK_W]. Held stable from toggle until ack.
- `clr_ack_tgl_hf` out `NUM_CH`: per-channel ack toggles, synchronised in each source domain.
- `clr_pulse` out 1: one-cycle clear strobe.
- `clr_mask` out `MASK_W`: clear mask; valid while `clr_pulse`=1 and held until the next pulse.
- `clr_src` out `NUM_CH`: channel(s) served by the current pulse; held with `clr_mask`.
- `busy` out 1: OR of all channel pending flags.
- `proto_err` out 1: sticky; set when a channel toggles again while still pending.

## Operation
- Per channel:
  - The toggle passes through `SYNC_STAGES` flops, then a prev flop; `edge = sync_last ^ prev`.
  - The mask passes through `SYNC_STAGES` flops, with no edge logic.
- On `edge`:
  - `pending`←1 and `cnt`←0.
  - If `pending` was already 1, also set `proto_err`; the counter restarts and still only one clear results.
- While pending, `cnt` increments and saturates at `SETTLE`. The channel is `ready` when `pending && cnt==SETTLE`.
- Arbiter (combinational, same cycle as ready):
  - `MERGE`=0: round-robin. The search starts at the channel after the last grant (ch0 after reset). One grant per cycle; ungranted ready channels stay ready.
  - `MERGE`=1: every ready channel is granted; the mask is the OR of their synced masks.
- On any grant, at the next edge:
  - `clr_pulse`←1.
  - `clr_mask`←captured synced mask (or OR of masks).
  - `clr_src`←grant vector.
  - Granted channels invert `clr_ack_tgl_hf` and clear `pending`.
  - The pointer updates.
- No grant: `clr_pulse`←0, and `clr_mask`/`clr_src` hold.
- `edge` arriving in the same cycle as that channel's grant: the grant completes (ack toggles), `pending` is re-armed and `proto_err` is set.

## Timing
- Reset values:
  - All outputs 0.
  - Ack toggles 0.
  - Pointer at ch0.
  - All sync, prev, pending and cnt state 0.
- Latency: a source toggle sampled first at HF edge k gives `clr_pulse` high after edge k+`SYNC_STAGES`+`SETTLE`+1 (k+5 for defaults), absent contention.
- Contention, `MERGE`=0: each additional ready channel adds exactly one cycle. Pulses may be back-to-back, one per cycle.
- Source rule: the mask is stable from before the toggle until ack. `SETTLE` ≥ source-to-HF skew ensures the synced mask is settled at capture.
- `SETTLE`=0: ready in the cycle after pending is set.
- Reset mid-operation:
  - All pending requests are dropped; no pulse is generated.
- HF-only reset while a source toggle is at 1:
  - One edge is detected and one clear executes.
  - The ack goes to 1, re-aligning the handshake. This is required behaviour.
- `proto_err` clears only on reset.

## Structure
- Package `status_cdc_pkg`:
  - `SETTLE_MAX`=15.
  - Default `MASK_W`/`NUM_CH` constants.
  - Function `rr_pick(ready, ptr)` returning a one-hot grant.
- Sub-module `status_clr_cdc_ch`:
  - Contains toggle sync, mask sync, edge detect, pending/cnt and the ack flop.
  - Inputs: `grant`. Outputs: `ready`, `mask_sync`, `ack_tgl`, `dup_edge`.
  - Instantiated `NUM_CH` times by generate.
- Top level contains the arbiter, output registers and `proto_err`.

## Test plan
- Reset defaults, single request: ch0 toggles with mask 0x2A5 → `clr_pulse` one cycle at k+5, `clr_mask`=0x2A5, `clr_src`=01, `ack[0]` toggles to 1, `busy` drops.
- Simultaneous requests, `MERGE`=0: ch0 mask 0x0003 and ch1 mask 0x3000 toggle at once → pulses at k+5 (ch0, 0x0003) and k+6 (ch1, 0x3000). The next simultaneous pair is served ch1 first.
- Same stimulus with `MERGE`=1 → single pulse, `clr_mask`=0x3003, `clr_src`=11, both acks toggle.
- Protocol error: ch0 toggles twice 1 cycle apart → exactly one pulse, `proto_err`=1 and stays 1 until reset.
- Reset mid-operation: assert `NRST_sync` at k+3 → no pulse, all outputs 0.
- HF-only reset with source toggle at 1 → one pulse after release, ack becomes 1.
- Parameter sweep: `SYNC_STAGES`=3, `SETTLE`=0, `MASK_W`=32, `NUM_CH`=4 → latency k+4, and a full-width mask 0xFFFFFFFF is delivered intact.

Source files
------------

// File: rtl/status_clear_cdc_mc_pkg.sv
// status_cdc_pkg: shared constants and round-robin pick helper for status_clear_cdc_mc; no ports
package status_cdc_pkg;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W = $clog2(SETTLE_MAX + 1);
  localparam int CH_MAX = 8;
  localparam int NUM_CH_DEF = 2;
  localparam int MASK_W_DEF = 14;
  function automatic logic [CH_MAX-1:0] rr_pick(input logic [CH_MAX-1:0] ready, input logic [2:0] ptr, input int n);
    logic [2:0] j;
    rr_pick = '0;
    for (int i = CH_MAX - 1; i >= 0; i--) begin
      j = 3'((int'(ptr) + i) % n);
      if (i < n && ready[j]) rr_pick = CH_MAX'(1) << j;
    end
  endfunction
endpackage

// File: rtl/status_clear_cdc_mc_if.sv
// status_clear_cdc_mc_if: source toggle/mask/ack handshake plus clear-pulse outputs; master = sources+monitor, slave = CDC block
interface status_clear_cdc_mc_if import status_cdc_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int MASK_W = MASK_W_DEF
);
  logic [NUM_CH-1:0] clr_req_tgl_src;
  logic [NUM_CH*MASK_W-1:0] clr_mask_src;
  logic [NUM_CH-1:0] clr_ack_tgl_hf;
  logic clr_pulse;
  logic [MASK_W-1:0] clr_mask;
  logic [NUM_CH-1:0] clr_src;
  logic busy;
  logic proto_err;
  modport master(output clr_req_tgl_src, clr_mask_src, input clr_ack_tgl_hf, clr_pulse, clr_mask, clr_src, busy, proto_err);
  modport slave(input clr_req_tgl_src, clr_mask_src, output clr_ack_tgl_hf, clr_pulse, clr_mask, clr_src, busy, proto_err);
endinterface

// File: rtl/status_clear_cdc_mc_ch.sv
// status_clr_cdc_ch: one channel (toggle/mask sync, edge detect, settle counter, ack toggle); in tgl_src/mask_src/grant, out ready/pending/mask_sync/ack_tgl/dup_edge
module status_clr_cdc_ch import status_cdc_pkg::*; #(
  parameter int MASK_W = MASK_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE = 2
) (
  input  logic HF_CLK,
  input  logic NRST_sync,
  input  logic tgl_src,
  input  logic [MASK_W-1:0] mask_src,
  input  logic grant,
  output logic ready,
  output logic pending,
  output logic [MASK_W-1:0] mask_sync,
  output logic ack_tgl,
  output logic dup_edge
);
  logic [SYNC_STAGES-1:0] tsync;
  logic [MASK_W-1:0] msync [SYNC_STAGES];
  logic prev, edge_det;
  logic [CNT_W-1:0] cnt;
  assign edge_det = tsync[SYNC_STAGES-1] ^ prev;
  assign dup_edge = edge_det & pending;
  assign ready = pending && cnt == CNT_W'(SETTLE);
  assign mask_sync = msync[SYNC_STAGES-1];
  always_ff @(posedge HF_CLK or negedge NRST_sync)
    if (!NRST_sync) begin
      tsync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) msync[i] <= '0;
      prev <= 1'b0;
      pending <= 1'b0;
      cnt <= '0;
      ack_tgl <= 1'b0;
    end else begin
      tsync <= {tsync[SYNC_STAGES-2:0], tgl_src};
      msync[0] <= mask_src;
      for (int i = 1; i < SYNC_STAGES; i++) msync[i] <= msync[i-1];
      prev <= tsync[SYNC_STAGES-1];
      pending <= edge_det | (pending & ~grant);
      cnt <= edge_det ? '0 : (pending && cnt != CNT_W'(SETTLE)) ? cnt + 1'b1 : cnt;
      ack_tgl <= ack_tgl ^ grant;
    end
endmodule

// File: rtl/status_clear_cdc_mc.sv
// status_clear_cdc_mc: multi-channel status-clear toggle CDC into HF_CLK with arbiter; ports HF_CLK, NRST_sync, bus (slave: toggles/masks in, acks/pulse/mask/src/busy/proto_err out)
module status_clear_cdc_mc import status_cdc_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int MASK_W = MASK_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE = 2,
  parameter int MERGE = 0
) (
  input logic HF_CLK,
  input logic NRST_sync,
  status_clear_cdc_mc_if.slave bus
);
  logic [NUM_CH-1:0] ready, pending, dup, grant;
  logic [MASK_W-1:0] msync [NUM_CH];
  logic [MASK_W-1:0] gmask;
  logic [CH_MAX-1:0] rr;
  logic [2:0] ptr, ptr_nxt;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    status_clr_cdc_ch #(.MASK_W(MASK_W), .SYNC_STAGES(SYNC_STAGES), .SETTLE(SETTLE)) u_ch (
      .HF_CLK(HF_CLK),
      .NRST_sync(NRST_sync),
      .tgl_src(bus.clr_req_tgl_src[c]),
      .mask_src(bus.clr_mask_src[c*MASK_W +: MASK_W]),
      .grant(grant[c]),
      .ready(ready[c]),
      .pending(pending[c]),
      .mask_sync(msync[c]),
      .ack_tgl(bus.clr_ack_tgl_hf[c]),
      .dup_edge(dup[c])
    );
  end
  assign bus.busy = |pending;
  // pointer names the channel the next round-robin search starts from
  always_comb begin
    rr = rr_pick(CH_MAX'(ready), ptr, NUM_CH);
    grant = MERGE != 0 ? ready : rr[NUM_CH-1:0];
    gmask = '0;
    ptr_nxt = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      gmask = gmask | (grant[i] ? msync[i] : '0);
      ptr_nxt = grant[i] ? 3'((i + 1) % NUM_CH) : ptr_nxt;
    end
  end
  always_ff @(posedge HF_CLK or negedge NRST_sync)
    if (!NRST_sync) begin
      bus.clr_pulse <= 1'b0;
      bus.clr_mask <= '0;
      bus.clr_src <= '0;
      bus.proto_err <= 1'b0;
      ptr <= '0;
    end else begin
      bus.clr_pulse <= |grant;
      if (|grant) begin
        bus.clr_mask <= gmask;
        bus.clr_src <= grant;
        ptr <= ptr_nxt;
      end
      bus.proto_err <= bus.proto_err | (|dup);
    end
endmodule

// File: tb/tb_status_clear_cdc_mc.sv
// tb_status_clear_cdc_mc: directed table plus corner sequences for round-robin, merge and wide/fast configurations
module tb_status_clear_cdc_mc;
  logic clk = 1'b0;
  logic NRST_sync = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  status_clear_cdc_mc_if #(.NUM_CH(2), .MASK_W(14)) if0 ();
  status_clear_cdc_mc_if #(.NUM_CH(2), .MASK_W(14)) if1 ();
  status_clear_cdc_mc_if #(.NUM_CH(4), .MASK_W(32)) if2 ();
  status_clear_cdc_mc #(.NUM_CH(2), .MASK_W(14), .SYNC_STAGES(2), .SETTLE(2), .MERGE(0)) u0 (.HF_CLK(clk), .NRST_sync(NRST_sync), .bus(if0));
  status_clear_cdc_mc #(.NUM_CH(2), .MASK_W(14), .SYNC_STAGES(2), .SETTLE(2), .MERGE(1)) u1 (.HF_CLK(clk), .NRST_sync(NRST_sync), .bus(if1));
  status_clear_cdc_mc #(.NUM_CH(4), .MASK_W(32), .SYNC_STAGES(3), .SETTLE(0), .MERGE(0)) u2 (.HF_CLK(clk), .NRST_sync(NRST_sync), .bus(if2));
  typedef struct {
    logic [1:0] flip;
    logic [13:0] m0, m1;
    logic [13:0] a_mask;
    logic [1:0] a_src;
    logic b_vld;
    logic [13:0] b_mask;
    logic [1:0] b_src;
    logic [13:0] m_mask;
    logic [1:0] m_src;
  } vec_t;
  vec_t tv [4];
  logic [1:0] tgl0 = '0, tgl1 = '0, ack0 = '0, ack1 = '0;
  logic [3:0] tgl2 = '0, ack2 = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_pulse0"}, 32'(if0.clr_pulse), 0);
    chk({tag, "_mask0"}, 32'(if0.clr_mask), 0);
    chk({tag, "_src0"}, 32'(if0.clr_src), 0);
    chk({tag, "_ack0"}, 32'(if0.clr_ack_tgl_hf), 0);
    chk({tag, "_busy0"}, 32'(if0.busy), 0);
    chk({tag, "_perr0"}, 32'(if0.proto_err), 0);
    chk({tag, "_pulse1"}, 32'(if1.clr_pulse), 0);
    chk({tag, "_ack1"}, 32'(if1.clr_ack_tgl_hf), 0);
    chk({tag, "_pulse2"}, 32'(if2.clr_pulse), 0);
    chk({tag, "_mask2"}, 32'(if2.clr_mask), 0);
  endtask
  initial begin
    int n0, n1;
    logic [13:0] lm0, lm1;
    logic [1:0] ls0, ls1;
    tv[0] = '{2'b11, 14'h0003, 14'h3000, 14'h0003, 2'b01, 1'b1, 14'h3000, 2'b10, 14'h3003, 2'b11};
    tv[1] = '{2'b01, 14'h02A5, 14'h3000, 14'h02A5, 2'b01, 1'b0, 14'h0000, 2'b00, 14'h02A5, 2'b01};
    tv[2] = '{2'b11, 14'h0003, 14'h3000, 14'h3000, 2'b10, 1'b1, 14'h0003, 2'b01, 14'h3003, 2'b11};
    tv[3] = '{2'b10, 14'h0003, 14'h3FFF, 14'h3FFF, 2'b10, 1'b0, 14'h0000, 2'b00, 14'h3FFF, 2'b10};
    if0.clr_req_tgl_src = '0; if0.clr_mask_src = '0;
    if1.clr_req_tgl_src = '0; if1.clr_mask_src = '0;
    if2.clr_req_tgl_src = '0; if2.clr_mask_src = '0;
    repeat (3) @(posedge clk);
    #1 chk_idle("rst");
    @(negedge clk) NRST_sync = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle("post_rst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if0.clr_mask_src = {tv[i].m1, tv[i].m0};
      if1.clr_mask_src = {tv[i].m1, tv[i].m0};
      tgl0 ^= tv[i].flip; tgl1 ^= tv[i].flip;
      if0.clr_req_tgl_src = tgl0; if1.clr_req_tgl_src = tgl1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1 chk($sformatf("v%0d_early0", i), 32'(if0.clr_pulse), 0);
      chk($sformatf("v%0d_early1", i), 32'(if1.clr_pulse), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_a_pulse", i), 32'(if0.clr_pulse), 1);
      chk($sformatf("v%0d_a_mask", i), 32'(if0.clr_mask), 32'(tv[i].a_mask));
      chk($sformatf("v%0d_a_src", i), 32'(if0.clr_src), 32'(tv[i].a_src));
      chk($sformatf("v%0d_m_pulse", i), 32'(if1.clr_pulse), 1);
      chk($sformatf("v%0d_m_mask", i), 32'(if1.clr_mask), 32'(tv[i].m_mask));
      chk($sformatf("v%0d_m_src", i), 32'(if1.clr_src), 32'(tv[i].m_src));
      ack0 ^= tv[i].a_src; ack1 ^= tv[i].m_src;
      @(posedge clk); #1;
      chk($sformatf("v%0d_b_pulse", i), 32'(if0.clr_pulse), 32'(tv[i].b_vld));
      if (tv[i].b_vld) begin
        chk($sformatf("v%0d_b_mask", i), 32'(if0.clr_mask), 32'(tv[i].b_mask));
        chk($sformatf("v%0d_b_src", i), 32'(if0.clr_src), 32'(tv[i].b_src));
        ack0 ^= tv[i].b_src;
      end
      chk($sformatf("v%0d_m_single", i), 32'(if1.clr_pulse), 0);
      chk($sformatf("v%0d_m_hold", i), 32'(if1.clr_mask), 32'(tv[i].m_mask));
      @(posedge clk); #1;
      chk($sformatf("v%0d_end_pulse0", i), 32'(if0.clr_pulse), 0);
      chk($sformatf("v%0d_ack0", i), 32'(if0.clr_ack_tgl_hf), 32'(ack0));
      chk($sformatf("v%0d_ack1", i), 32'(if1.clr_ack_tgl_hf), 32'(ack1));
      chk($sformatf("v%0d_busy0", i), 32'(if0.busy), 0);
      chk($sformatf("v%0d_busy1", i), 32'(if1.busy), 0);
    end
    @(negedge clk) tgl0 ^= 2'b01; if0.clr_req_tgl_src = tgl0;
    @(negedge clk) tgl0 ^= 2'b01; if0.clr_req_tgl_src = tgl0;
    n0 = 0; ls0 = '0;
    repeat (14) begin
      @(posedge clk); #1;
      if (if0.clr_pulse) begin n0++; ls0 = if0.clr_src; end
    end
    ack0 ^= 2'b01;
    chk("perr_pulses", 32'(n0), 1);
    chk("perr_src", 32'(ls0), 32'(2'b01));
    chk("perr_flag", 32'(if0.proto_err), 1);
    chk("perr_ack", 32'(if0.clr_ack_tgl_hf), 32'(ack0));
    chk("perr_other", 32'(if1.proto_err), 0);
    repeat (6) @(posedge clk);
    #1 chk("perr_sticky", 32'(if0.proto_err), 1);
    @(negedge clk);
    if0.clr_mask_src = {14'h2AAA, 14'h0155};
    if1.clr_mask_src = {14'h2AAA, 14'h0155};
    tgl0 ^= 2'b10; if0.clr_req_tgl_src = tgl0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("mid_busy_before", 32'(if0.busy), 1);
    NRST_sync = 1'b0;
    #1 chk_idle("mid_rst");
    n0 = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if0.clr_pulse || if1.clr_pulse) n0++;
    end
    chk("mid_rst_nopulse", 32'(n0), 0);
    @(negedge clk) NRST_sync = 1'b1;
    ack0 = '0; ack1 = '0;
    n0 = 0; n1 = 0; lm0 = '0; lm1 = '0; ls0 = '0; ls1 = '0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if0.clr_pulse) begin n0++; lm0 = if0.clr_mask; ls0 = if0.clr_src; end
      if (if1.clr_pulse) begin n1++; lm1 = if1.clr_mask; ls1 = if1.clr_src; end
    end
    chk("hfrst_pulses0", 32'(n0), 1);
    chk("hfrst_src0", 32'(ls0), 32'(2'b01));
    chk("hfrst_mask0", 32'(lm0), 32'(14'h0155));
    chk("hfrst_ack0", 32'(if0.clr_ack_tgl_hf), 32'(2'b01));
    chk("hfrst_perr0", 32'(if0.proto_err), 0);
    chk("hfrst_pulses1", 32'(n1), 1);
    chk("hfrst_src1", 32'(ls1), 32'(2'b11));
    chk("hfrst_mask1", 32'(lm1), 32'(14'h2BFF));
    chk("hfrst_ack1", 32'(if1.clr_ack_tgl_hf), 32'(2'b11));
    @(negedge clk);
    if2.clr_mask_src = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    tgl2 ^= 4'b0100; if2.clr_req_tgl_src = tgl2;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("w_early", 32'(if2.clr_pulse), 0);
    @(posedge clk); #1;
    chk("w_pulse", 32'(if2.clr_pulse), 1);
    chk("w_mask", if2.clr_mask, 32'hFFFF_FFFF);
    chk("w_src", 32'(if2.clr_src), 32'(4'b0100));
    ack2 ^= 4'b0100;
    @(posedge clk); #1 chk("w_single", 32'(if2.clr_pulse), 0);
    @(negedge clk);
    if2.clr_mask_src = {32'h89AB_CDEF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    tgl2 ^= 4'b1010; if2.clr_req_tgl_src = tgl2;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("w_rr_a_src", 32'(if2.clr_src), 32'(4'b1000));
    chk("w_rr_a_mask", if2.clr_mask, 32'h89AB_CDEF);
    @(posedge clk); #1;
    chk("w_rr_b_pulse", 32'(if2.clr_pulse), 1);
    chk("w_rr_b_src", 32'(if2.clr_src), 32'(4'b0010));
    chk("w_rr_b_mask", if2.clr_mask, 32'h1234_5678);
    ack2 ^= 4'b1010;
    @(posedge clk); #1;
    chk("w_rr_end", 32'(if2.clr_pulse), 0);
    chk("w_ack", 32'(if2.clr_ack_tgl_hf), 32'(ack2));
    chk("w_busy", 32'(if2.busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
